fifo_stream_reader: RTL and testbench

- Drains a single-read FIFO (registered BRAM read, 1-cycle read latency, empty flag) and presents its words as a valid/ready stream to the next compute stage.
- Hides the BRAM read latency with a 2-entry output buffer and a credit check, sustaining 1 word/cycle.
- Tags the final word of each fixed-length frame (e.g. one feature-map row or tile) with a last flag.

---
 rtl/stream_buffer_2.sv | 34 +++
 rtl/fifo_stream_reader.sv | 55 +++++
 tb/tb_fifo_stream_reader.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/stream_buffer_2.sv
// stream_buffer_2: two-entry FIFO-ordered holding register; entry 0 is always the head.
module stream_buffer_2 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            count
);
    logic [DATA_WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]            cnt_q, cnt_d, pos;
    always_comb begin
        pos   = cnt_q - {1'b0, rd_en};
        e0_d  = (wr_en && pos == 2'd0) ? wr_data : (rd_en ? e1_q : e0_q);
        e1_d  = (wr_en && pos == 2'd1) ? wr_data : e1_q;
        cnt_d = pos + {1'b0, wr_en};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end
    assign rd_data = e0_q;
    assign count   = cnt_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a 1-cycle-latency FIFO into a valid/ready stream with per-frame last tagging.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_last,
    input  logic                  i_ready,
    output logic                  frame_done
);
    localparam int            CW       = $clog2(FRAME_LEN) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
    logic [1:0]    buf_cnt;
    logic [2:0]    occ;
    logic          pop, inflight_q, inflight_d, frame_done_q, frame_done_d;
    logic [CW-1:0] word_cnt_q, word_cnt_d;
    stream_buffer_2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (inflight_q),
        .wr_data (fifo_rd_data),
        .rd_en   (pop),
        .rd_data (o_data),
        .count   (buf_cnt)
    );
    assign o_valid    = buf_cnt != 2'd0;
    assign o_last     = o_valid & (word_cnt_q == LAST_IDX);
    assign frame_done = frame_done_q;
    // Credit counts the word leaving this cycle so reads continue back-to-back at full rate.
    always_comb begin
        pop          = o_valid & i_ready;
        occ          = {1'b0, buf_cnt} + {2'b0, inflight_q} - {2'b0, pop};
        fifo_rd_en   = ~fifo_empty & (occ < 3'd2);
        inflight_d   = fifo_rd_en;
        word_cnt_d   = pop ? ((word_cnt_q == LAST_IDX) ? '0 : word_cnt_q + CW'(1)) : word_cnt_q;
        frame_done_d = pop & o_last;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q   <= 1'b0;
            word_cnt_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            inflight_q   <= inflight_d;
            word_cnt_q   <= word_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: FIFO model feeds the reader; a negedge monitor scores every accepted word.
module tb_fifo_stream_reader;
    localparam int DW = 32;
    localparam int FL = 4;
    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;
    logic          clk = 1'b0, rst_n = 1'b0, i_ready = 1'b0;
    logic          fifo_rd_en, fifo_empty, o_valid, o_last, frame_done;
    logic [DW-1:0] fifo_rd_data = '0, o_data;
    logic [DW-1:0] mem [0:255];
    int unsigned   wr_ptr = 0, rd_ptr = 0;
    exp_t          exp_q [$];
    exp_t          e;
    int            n_checks = 0, n_pass = 0;
    logic          fd_exp = 1'b0, stall_q = 1'b0, held_l = 1'b0;
    logic [DW-1:0] held_d = '0;
    always #5 clk = ~clk;
    assign fifo_empty = (rd_ptr == wr_ptr);
    fifo_stream_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_last       (o_last),
        .i_ready      (i_ready),
        .frame_done   (frame_done)
    );
    // FIFO shares rst_n, so a reset flushes whatever it still holds.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_ptr <= wr_ptr;
        else if (fifo_rd_en) begin
            fifo_rd_data <= mem[rd_ptr % 256];
            rd_ptr       <= rd_ptr + 1;
        end
    end
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    endtask
    task automatic push(input logic [DW-1:0] d, input logic l);
        mem[wr_ptr % 256] = d;
        wr_ptr++;
        exp_q.push_back({d, l});
    endtask
    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain words left", exp_q.size(), 0);
    endtask
    always @(negedge clk) begin
        if (!rst_n) begin
            fd_exp  = 1'b0;
            stall_q = 1'b0;
        end else begin
            chk("frame_done", frame_done, fd_exp);
            chk("occupancy<=2", (dut.buf_cnt + dut.inflight_q) <= 2, 1);
            chk("read while empty", fifo_rd_en & fifo_empty, 0);
            if (stall_q) begin
                chk("stall valid", o_valid, 1);
                chk("stall data", o_data, held_d);
                chk("stall last", o_last, held_l);
            end
            fd_exp = 1'b0;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) chk("spurious word", exp_q.size() != 0, 1);
                else begin
                    e = exp_q.pop_front();
                    chk("data", o_data, e.d);
                    chk("last", o_last, e.l);
                end
                fd_exp = o_last;
            end
            stall_q = o_valid && !i_ready;
            held_d  = o_data;
            held_l  = o_last;
        end
    end
    initial begin
        logic [39:0] rdy_pat;
        int          rd_cnt;
        rdy_pat = 40'b1011011101_1101101110_0111011011_1011101101;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle rd_en", fifo_rd_en, 0);
            chk("idle valid", o_valid, 0);
            chk("idle data", o_data, 0);
        end
        @(posedge clk); #1;
        i_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(i, i % 4 == 0);
        @(negedge clk);
        chk("lat rd_en c0", fifo_rd_en, 1);
        chk("lat valid c0", o_valid, 0);
        @(negedge clk);
        chk("lat valid c1", o_valid, 0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("thru valid", o_valid, 1);
            chk("thru data", o_data, i);
        end
        repeat (2) @(negedge clk);
        chk("after burst valid", o_valid, 0);
        @(posedge clk); #1;
        i_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(32'h100 + i, i % 4 == 3);
        rd_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            rd_cnt += int'(fifo_rd_en);
        end
        chk("reads before stall", rd_cnt, 2);
        chk("stalled valid", o_valid, 1);
        chk("stalled head", o_data, 32'h100);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            i_ready = rdy_pat[i];
        end
        @(posedge clk); #1;
        i_ready = 1'b1;
        drain();
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) push(i, i == 3 || i == 7);
        drain();
        repeat (2) @(negedge clk);
        chk("word_cnt after frame", dut.word_cnt_q, 2);
        @(posedge clk); #1;
        push(32'hA0, 1'b0);
        push(32'hA1, 1'b1);
        push(32'hA2, 1'b0);
        drain();
        repeat (3) @(negedge clk);
        chk("underrun valid", o_valid, 0);
        chk("underrun rd_en", fifo_rd_en, 0);
        repeat (5) @(posedge clk); #1;
        push(32'hA3, 1'b0);
        push(32'hA4, 1'b0);
        push(32'hA5, 1'b1);
        drain();
        @(posedge clk); #1;
        push(32'hB0, 1'b0);
        drain();
        @(posedge clk); #1;
        i_ready = 1'b0;
        push(32'hB1, 1'b0);
        push(32'hB2, 1'b0);
        push(32'hB3, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst rd_en", fifo_rd_en, 0);
        chk("rst valid", o_valid, 0);
        chk("rst last", o_last, 0);
        chk("rst data", o_data, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst word_cnt", dut.word_cnt_q, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(32'hC0 + i, i == 3);
        drain();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
